// File: rtl/modexp_iter.sv
// modexp_iter -- iterative modular exponentiator, result = base^exponent mod modulus.
//
// Left-to-right square-and-multiply. Every modular multiply is a bit-serial
// interleaved shift/add/subtract multiplier that consumes one multiplier bit per
// clock, so no wide multiplier and no division are needed. All exponent bits are
// scanned (leading zeros included), so latency depends only on the popcount of
// the exponent:
//   WIDTH*(1 + EXP_WIDTH + popcount(exponent)) + 1 cycles from the start-sampling
//   edge to the edge that registers done (1 cycle when modulus < 2).
//
// Parameters:
//   WIDTH      bit width of base, modulus and result
//   EXP_WIDTH  bit width of exponent
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      request pulse, sampled only while idle
//   base       base (any value; reduced mod modulus internally)
//   exponent   exponent (0 allowed)
//   modulus    modulus (>= 2 for a valid result)
//   busy       high from the cycle after acceptance until done
//   done       one-cycle pulse when result is valid
//   err        set with done when modulus < 2, cleared at the next accepted start
//   result     last result, held until the next accepted start
//   cycle_cnt  (only with MODEXP_CYCLE_CNT_EN defined) busy-cycle counter
//
// Optional feature: define MODEXP_CYCLE_CNT_EN to add the 32-bit cycle_cnt port.
module modexp_iter #(
  parameter int WIDTH     = 100,
  parameter int EXP_WIDTH = WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
`ifdef MODEXP_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(WIDTH - 1);
  localparam logic [IW-1:0] I_TOP  = IW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     base_reg;
  logic [WIDTH-1:0]     mod_reg;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic [WIDTH-1:0]     acc_reg;   // running power
  logic [WIDTH-1:0]     bred_reg;  // base reduced mod modulus
  logic [WIDTH-1:0]     p_reg;     // partial product, always < modulus
  logic [JW-1:0]        j_reg;     // multiplier bit index within one multiply
  logic [IW-1:0]        i_reg;     // exponent bit index

  // One step of the interleaved multiplier. Intermediates are one bit wider
  // than the operands so 2p and p+b cannot overflow, even for modulus 2^WIDTH-1.
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   p_dbl;
  logic [WIDTH:0]   p_dbl_red;
  logic [WIDTH:0]   p_add;
  logic [WIDTH-1:0] p_next;

  always_comb begin
    mm_a = acc_reg;
    mm_b = acc_reg;
    case (state_reg)
      S_PRE: begin
        // MM(base, 1) is simply base mod m; base itself may exceed m.
        mm_a = base_reg;
        mm_b = WIDTH'(1);
      end
      S_MUL:   mm_b = bred_reg;
      default: ;
    endcase
    m_ext     = {1'b0, mod_reg};
    p_dbl     = {p_reg, 1'b0};
    p_dbl_red = (p_dbl >= m_ext) ? (p_dbl - m_ext) : p_dbl;
    p_add     = mm_a[j_reg] ? (p_dbl_red + {1'b0, mm_b}) : p_dbl_red;
    p_next    = (p_add >= m_ext) ? WIDTH'(p_add - m_ext) : p_add[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      base_reg  <= '0;
      mod_reg   <= '0;
      exp_reg   <= '0;
      acc_reg   <= '0;
      bred_reg  <= '0;
      p_reg     <= '0;
      j_reg     <= '0;
      i_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
`ifdef MODEXP_CYCLE_CNT_EN
      cycle_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_reg <= base;
            exp_reg  <= exponent;
            mod_reg  <= modulus;
            err      <= 1'b0;
            busy     <= 1'b1;
            p_reg    <= '0;
            j_reg    <= J_LAST;
            i_reg    <= I_TOP;
`ifdef MODEXP_CYCLE_CNT_EN
            cycle_cnt <= '0;
`endif
            if (modulus < WIDTH'(2)) begin
              acc_reg   <= '0;
              state_reg <= S_DONE;
            end else begin
              acc_reg   <= WIDTH'(1);
              state_reg <= S_PRE;
            end
          end
        end

        S_PRE, S_SQR, S_MUL: begin
`ifdef MODEXP_CYCLE_CNT_EN
          cycle_cnt <= cycle_cnt + 32'd1;
`endif
          p_reg <= p_next;
          j_reg <= j_reg - JW'(1);
          if (j_reg == '0) begin
            // Multiply finished: restart the multiplier and route its product.
            p_reg <= '0;
            j_reg <= J_LAST;
            if (state_reg == S_PRE) begin
              bred_reg  <= p_next;
              state_reg <= S_SQR;
            end else begin
              acc_reg <= p_next;
              if (state_reg == S_SQR && exp_reg[i_reg]) begin
                state_reg <= S_MUL;
              end else if (i_reg == '0) begin
                state_reg <= S_DONE;
              end else begin
                i_reg     <= i_reg - IW'(1);
                state_reg <= S_SQR;
              end
            end
          end
        end

        S_DONE: begin
          // A start seen in this cycle is deliberately not sampled.
          result    <= acc_reg;
          err       <= (mod_reg < WIDTH'(2));
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_iter.sv
// tb_modexp_iter -- directed self-checking bench for modexp_iter (WIDTH=16).
// Covers reset values, several exponentiations with hand-computed results and
// latencies, modulus < 2 error path, ignored mid-run start, start during the
// DONE cycle followed by a back-to-back start, and an asynchronous abort.
// Works with or without MODEXP_CYCLE_CNT_EN defined.
module tb_modexp_iter;

  localparam int W  = 16;
  localparam int EW = 17;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exponent;
  logic [W-1:0]  modulus;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
`ifdef MODEXP_CYCLE_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  modexp_iter #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
`ifdef MODEXP_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic apply(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    base     = b;
    exponent = e;
    modulus  = m;
    start    = 1'b1;
  endtask

  // Entered with start already high, before the acceptance edge.
  // ignore_at > 0: pulse start with other inputs at that cycle (must be ignored).
  // b2b = 1: raise start with the next operands during the DONE cycle and leave it
  //          high, so the next call sees it accepted on the cycle after done.
  task automatic run_op(input string tag, input logic [W-1:0] exp_res, input logic exp_err,
                        input int exp_lat, input int ignore_at, input bit b2b,
                        input logic [W-1:0] nb, input logic [EW-1:0] ne,
                        input logic [W-1:0] nm);
    int cycles;
    bit got;
    bit busy_ok;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " accept busy"}, 32'(busy), 32'd1);
    check({tag, " accept err"}, 32'(err), 32'd0);
    cycles  = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && cycles < exp_lat + 50) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (ignore_at > 0 && cycles == ignore_at) apply(16'd10, 17'd3, 16'd7);
        if (ignore_at > 0 && cycles == ignore_at + 1) start = 1'b0;
        if (b2b && cycles == exp_lat - 1) apply(nb, ne, nm);
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " busy held"}, 32'(busy_ok), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
`ifdef MODEXP_CYCLE_CNT_EN
    check({tag, " cycle_cnt"}, cycle_cnt, 32'(exp_lat - 1));
`endif
    if (!b2b) begin
      @(posedge clk); #1;
      check({tag, " done pulse width"}, 32'(done), 32'd0);
      check({tag, " result held"}, 32'(result), 32'(exp_res));
    end
    $display("op %s: result=%0d err=%0d latency=%0d", tag, result, err, cycles);
  endtask

  initial begin
    int cycles;
    bit got;
    rst      = 1'b1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset result", 32'(result), 32'd0);
`ifdef MODEXP_CYCLE_CNT_EN
    check("reset cycle_cnt", cycle_cnt, 32'd0);
`endif
    rst = 1'b0;

    // 4^13 mod 497 = 445, popcount 3 -> 16*21+1
    @(negedge clk); apply(16'd4, 17'd13, 16'd497);
    run_op("4^13%497", 16'd445, 1'b0, 337, 0, 1'b0, '0, '0, '0);

    // base >= modulus: 10^3 mod 7 = 1000 mod 7 = 6, popcount 2 -> 16*20+1
    @(negedge clk); apply(16'd10, 17'd3, 16'd7);
    run_op("10^3%7", 16'd6, 1'b0, 321, 0, 1'b0, '0, '0, '0);

    // exponent 0 -> 1, latency 16*18+1
    @(negedge clk); apply(16'd5, 17'd0, 16'd7);
    run_op("5^0%7", 16'd1, 1'b0, 289, 0, 1'b0, '0, '0, '0);

    // modulus < 2 -> err, result 0, done one cycle after acceptance
    @(negedge clk); apply(16'd9, 17'd5, 16'd1);
    run_op("mod1", 16'd0, 1'b1, 1, 0, 1'b0, '0, '0, '0);

    // Fermat: 65535 = 14 mod 65521, 14^(p-1) = 1, popcount 12 -> 16*30+1
    @(negedge clk); apply(16'd65535, 17'd65520, 16'd65521);
    run_op("fermat", 16'd1, 1'b0, 481, 0, 1'b0, '0, '0, '0);

    // base = 0, exponent > 0 -> 0; popcount(5)=2 -> 321
    @(negedge clk); apply(16'd0, 17'd5, 16'd11);
    run_op("0^5%11", 16'd0, 1'b0, 321, 0, 1'b0, '0, '0, '0);

    // Second start at cycle 50 ignored; start during DONE ignored and held into
    // the next cycle, where it is accepted back-to-back with 10/3/7.
    @(negedge clk); apply(16'd4, 17'd13, 16'd497);
    run_op("ignore", 16'd445, 1'b0, 337, 50, 1'b1, 16'd10, 17'd3, 16'd7);
    run_op("b2b", 16'd6, 1'b0, 321, 0, 1'b0, '0, '0, '0);

    // Asynchronous abort at cycle 100 of a run.
    @(negedge clk); apply(16'd4, 17'd13, 16'd497);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    cycles = 0;
    while (cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (done || busy) got = 1'b1;
    end
    check("abort no done", 32'(got), 32'd0);
    $display("op abort: busy/done activity after reset=%0d", got);

    @(negedge clk); apply(16'd4, 17'd13, 16'd497);
    run_op("after abort", 16'd445, 1'b0, 337, 0, 1'b0, '0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
